control_fsm: RTL and testbench
==============================

// Module: control_fsm
// PURPOSE
//  Multi-cycle successor to the GPP16 single-cycle decoder: sequences ADD/SUB/MUL/DIV/MOD/MOV
//  through FETCH/DECODE/WAIT/WB states.
//  Accepts opcodes from fetch over a valid/ready handshake and drives the datapath.
//  Handles multi-cycle ALU ops via an alu_start/alu_done handshake, with a timeout.
//  Halts on HLT (opcode 31).
// PARAMETERS
//  OPW        5         opcode width; OP_HLT = all ones ({OPW{1'b1}})
//  FUNCW      5         alu_func width; alu_func = zero-extended/truncated opcode
//  NUM_OPS    6         opcodes 0..NUM_OPS-1 are implemented (0=ADD..5=MOV)
//  MC_MASK    32'h18    bit i set => opcode i is multi-cycle (default DIV=3, MOD=4)
//  ALU_TMO    64        max WAIT cycles before fault; counter width $clog2(ALU_TMO+1)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  instr_valid  in   1      fetch presents opcode
//  instr_ready  out  1      control accepts opcode (FETCH state only)
//  opcode       in   OPW    opcode, sampled on valid&&ready
//  alu_func     out  FUNCW  ALU op select, from latched opcode
//  alu_start    out  1      one-cycle pulse launching a multi-cycle ALU op
//  alu_done     in   1      ALU result ready (multi-cycle ops)
//  we3          out  1      register-file write enable
//  pc_en        out  1      PC advance strobe, coincident with retire
//  halted       out  1      HALT state reached
//  fault        out  1      sticky: ALU timeout (or illegal op, see CONFIGURATION)
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-low.
//  - Reset (rst_n=0, any time, incl. mid-WAIT):
//    - state=FETCH, op_q=0, tmo counter=0, fault=0.
//    - All outputs 0 except instr_ready=1 once out of reset.
//  - Moore FSM; all outputs decode from state/op_q/fault only, no comb path from inputs.
//  - FETCH: instr_ready=1. On instr_valid=1, latch op_q<=opcode and go to DECODE.
//    Otherwise stay.
//  - DECODE (1 cycle): alu_func=op_q.
//    - op_q==OP_HLT -> HALT.
//    - op_q<NUM_OPS && !MC_MASK[op_q] -> WB.
//    - op_q<NUM_OPS && MC_MASK[op_q] -> alu_start=1 this cycle; go to WAIT; tmo<=0.
//    - Otherwise unimplemented -> see CONFIGURATION.
//  - WAIT: alu_func=op_q; tmo increments each cycle.
//    - alu_done=1 -> WB. alu_done takes priority over timeout in the same cycle.
//    - tmo==ALU_TMO-1 with no done -> HALT, fault<=1, no write.
//    - alu_done outside WAIT is ignored.
//  - WB (1 cycle): we3=1, pc_en=1, alu_func=op_q; next state FETCH.
//  - HALT: halted=1, instr_ready=0, all other strobes 0. Exits only via reset.
//  - Latency:
//    - single-cycle op accepted at edge N -> DECODE in N..N+1, WB in N+1..N+2,
//      instr_ready high again from N+2.
//    - Peak throughput: 1 instr / 3 cycles.
//    - Multi-cycle op: 3 cycles + WAIT cycles (WAIT >= 1 cycle).
//  - alu_func=0 in FETCH and HALT.
//  - MC_MASK bits >= NUM_OPS are ignored.
// CONFIGURATION
//  CTRL_ILLEGAL_TRAP_EN
//    - Defined: unimplemented non-HLT opcode in DECODE -> HALT, fault<=1.
//    - Undefined: such an opcode retires as a NOP. DECODE -> FETCH with we3=0, pc_en=0
//      (fetch holds the PC; no retire). fault is untouched.
//      This matches the legacy silent-ignore behaviour.
// TESTING
//  1. Reset mid-WAIT (op 3, alu_done held 0): rst_n=0 for 1 cycle, async ->
//     state FETCH, we3=0, alu_start=0, fault=0, instr_ready=1 after release.
//  2. ADD: opcode=0, valid for 1 cycle ->
//     alu_func=0 in DECODE, we3=pc_en=1 exactly 1 cycle, 2 cycles after acceptance;
//     alu_start never asserted.
//  3. DIV: opcode=3, alu_done after 5 WAIT cycles ->
//     alu_start=1 for the single DECODE cycle, we3=1 on the cycle after done,
//     alu_func=3 throughout.
//  4. Timeout: opcode=4, alu_done never ->
//     HALT after ALU_TMO WAIT cycles, fault=1, halted=1, we3 never 1.
//     A later valid is not accepted.
//  5. Opcode=9:
//     - with CTRL_ILLEGAL_TRAP_EN: halted=1, fault=1.
//     - without: back to FETCH after 1 DECODE cycle, we3=0, next opcode=1 executes normally.
//  6. Back-to-back: valid held 1 with opcodes 1,5,31 ->
//     two WB pulses 3 cycles apart with alu_func 1 then 5; then halted=1, instr_ready=0.

Source files
------------

// File: rtl/control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : control_fsm
//  Purpose  : Multi-cycle instruction sequencer (FETCH/DECODE/WAIT/WB/HALT).
//             Accepts opcodes over valid/ready, drives ALU select, launches
//             multi-cycle ALU ops with a timeout, retires via we3/pc_en and
//             halts on the all-ones opcode.
//  Options  : CTRL_ILLEGAL_TRAP_EN - unimplemented opcodes halt with fault
//             (undefined: they are dropped as a NOP and fetch resumes).
//  Revision : 1.0 - initial release
// ============================================================================
module control_fsm #(
  parameter int          OPW     = 5,
  parameter int          FUNCW   = 5,
  parameter int          NUM_OPS = 6,
  parameter logic [31:0] MC_MASK = 32'h18,
  parameter int          ALU_TMO = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [OPW-1:0]   opcode,
  output logic [FUNCW-1:0] alu_func,
  output logic             alu_start,
  input  logic             alu_done,
  output logic             we3,
  output logic             pc_en,
  output logic             halted,
  output logic             fault
);

  localparam int              TMOW     = $clog2(ALU_TMO + 1);
  localparam logic [OPW-1:0]  OP_HLT   = {OPW{1'b1}};
  localparam logic [TMOW-1:0] TMO_LAST = TMOW'(ALU_TMO - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_WAIT   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t             state_q;
  logic [OPW-1:0]     op_q;
  logic [TMOW-1:0]    tmo_q;
  logic               fault_q;
  logic               instr_ready_q;
  logic [FUNCW-1:0]   alu_func_q;
  logic               alu_start_q;
  logic               we3_q;
  logic               pc_en_q;
  logic               halted_q;

  // Opcode lies inside the implemented range.
  function automatic logic is_legal(input logic [OPW-1:0] op);
    return (int'(op) < NUM_OPS);
  endfunction

  // Implemented opcode whose MC_MASK bit marks it multi-cycle; mask bits at or
  // above NUM_OPS never matter because of the legality gate.
  function automatic logic is_mc(input logic [OPW-1:0] op);
    logic [31:0] sh;
    sh = MC_MASK >> op;
    return is_legal(op) && sh[0];
  endfunction

  // Sequencer: every output is a register loaded together with the state it
  // belongs to, so outputs are pure Moore and glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      op_q          <= '0;
      tmo_q         <= '0;
      fault_q       <= 1'b0;
      instr_ready_q <= 1'b1;
      alu_func_q    <= '0;
      alu_start_q   <= 1'b0;
      we3_q         <= 1'b0;
      pc_en_q       <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (instr_valid) begin
            state_q       <= S_DECODE;
            op_q          <= opcode;
            instr_ready_q <= 1'b0;
            alu_func_q    <= FUNCW'(opcode);
            alu_start_q   <= is_mc(opcode);
          end
        end
        S_DECODE: begin
          alu_start_q <= 1'b0;
          if (op_q == OP_HLT) begin
            state_q    <= S_HALT;
            halted_q   <= 1'b1;
            alu_func_q <= '0;
          end else if (is_mc(op_q)) begin
            state_q <= S_WAIT;
            tmo_q   <= '0;
          end else if (is_legal(op_q)) begin
            state_q <= S_WB;
            we3_q   <= 1'b1;
            pc_en_q <= 1'b1;
          end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_q    <= S_HALT;
            halted_q   <= 1'b1;
            fault_q    <= 1'b1;
            alu_func_q <= '0;
`else
            // Dropped without retiring: the PC is not advanced.
            state_q       <= S_FETCH;
            instr_ready_q <= 1'b1;
            alu_func_q    <= '0;
`endif
          end
        end
        S_WAIT: begin
          tmo_q <= tmo_q + 1'b1;
          if (alu_done) begin
            state_q <= S_WB;
            we3_q   <= 1'b1;
            pc_en_q <= 1'b1;
          end else if (tmo_q == TMO_LAST) begin
            state_q    <= S_HALT;
            halted_q   <= 1'b1;
            fault_q    <= 1'b1;
            alu_func_q <= '0;
          end
        end
        S_WB: begin
          state_q       <= S_FETCH;
          we3_q         <= 1'b0;
          pc_en_q       <= 1'b0;
          instr_ready_q <= 1'b1;
          alu_func_q    <= '0;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q       <= S_FETCH;
          instr_ready_q <= 1'b1;
          alu_func_q    <= '0;
          alu_start_q   <= 1'b0;
          we3_q         <= 1'b0;
          pc_en_q       <= 1'b0;
          halted_q      <= 1'b0;
        end
      endcase
    end
  end

  assign instr_ready = instr_ready_q;
  assign alu_func    = alu_func_q;
  assign alu_start   = alu_start_q;
  assign we3         = we3_q;
  assign pc_en       = pc_en_q;
  assign halted      = halted_q;
  assign fault       = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_fsm
//  Purpose  : Scoreboard bench for control_fsm. Stimulus pushes expected
//             events (ALU start, retire, halt); a monitor pops and compares
//             them as the DUT presents them. Timing checks run inline.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_control_fsm;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [4:0] opcode;
  logic [4:0] alu_func;
  logic       alu_start;
  logic       alu_done;
  logic       we3;
  logic       pc_en;
  logic       halted;
  logic       fault;

  localparam logic [1:0] K_START = 2'd0;
  localparam logic [1:0] K_WB    = 2'd1;
  localparam logic [1:0] K_HALT  = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [4:0] func;
    logic       flt;
  } ev_t;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;

  control_fsm dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .alu_func    (alu_func),
    .alu_start   (alu_start),
    .alu_done    (alu_done),
    .we3         (we3),
    .pc_en       (pc_en),
    .halted      (halted),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [4:0] f, input logic fl);
    ev_t e;
    e.kind = k;
    e.func = f;
    e.flt  = fl;
    sb.push_back(e);
  endtask

  // Monitor: pops one expected event per observed DUT event.
  logic halted_prev = 1'b0;
  always @(negedge clk) begin
    ev_t e;
    if (!rst_n) begin
      halted_prev = 1'b0;
    end else begin
      if (alu_start) begin
        if (sb.size() == 0) chk("unexpected_start", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("start_kind", 32'(e.kind), 32'(K_START));
          chk("start_func", 32'(alu_func), 32'(e.func));
        end
      end
      if (we3) begin
        if (sb.size() == 0) chk("unexpected_wb", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("wb_kind", 32'(e.kind), 32'(K_WB));
          chk("wb_func", 32'(alu_func), 32'(e.func));
          chk("wb_pc_en", 32'(pc_en), 32'd1);
        end
      end
      if (halted && !halted_prev) begin
        if (sb.size() == 0) chk("unexpected_halt", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("halt_kind", 32'(e.kind), 32'(K_HALT));
          chk("halt_fault", 32'(fault), 32'(e.flt));
          chk("halt_func", 32'(alu_func), 32'd0);
        end
      end
      halted_prev = halted;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents op for one cycle; on return the op was accepted at the last edge.
  task automatic issue(input logic [4:0] op);
    tick();
    instr_valid = 1'b1;
    opcode      = op;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    int wb1;
    int wb2;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    opcode      = '0;
    alu_done    = 1'b0;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    chk("rst_we3", 32'(we3), 32'd0);
    chk("rst_alu_start", 32'(alu_start), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_alu_func", 32'(alu_func), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd1);

    // 1: reset in the middle of WAIT
    push(K_START, 5'd3, 1'b0);
    issue(5'd3);
    tick();
    tick();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we3", 32'(we3), 32'd0);
    chk("mid_rst_alu_start", 32'(alu_start), 32'd0);
    chk("mid_rst_fault", 32'(fault), 32'd0);
    chk("mid_rst_alu_func", 32'(alu_func), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(instr_ready), 32'd1);

    // 2: ADD retires two cycles after acceptance
    push(K_WB, 5'd0, 1'b0);
    issue(5'd0);
    @(negedge clk);
    chk("add_decode_func", 32'(alu_func), 32'd0);
    chk("add_decode_we3", 32'(we3), 32'd0);
    @(negedge clk);
    chk("add_wb_we3", 32'(we3), 32'd1);
    @(negedge clk);
    chk("add_after_we3", 32'(we3), 32'd0);
    chk("add_after_ready", 32'(instr_ready), 32'd1);

    // 3: DIV, alu_done in the fifth WAIT cycle
    push(K_START, 5'd3, 1'b0);
    push(K_WB, 5'd3, 1'b0);
    issue(5'd3);
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 5) alu_done = 1'b1;
      @(negedge clk);
      chk("div_wait_func", 32'(alu_func), 32'd3);
      chk("div_wait_we3", 32'(we3), 32'd0);
    end
    tick();
    alu_done = 1'b0;
    @(negedge clk);
    chk("div_wb_we3", 32'(we3), 32'd1);
    @(negedge clk);
    chk("div_done_ready", 32'(instr_ready), 32'd1);

    // 4: MOD with no alu_done times out after 64 WAIT cycles
    push(K_START, 5'd4, 1'b0);
    push(K_HALT, 5'd0, 1'b1);
    issue(5'd4);
    k = 1;
    while (k <= 200) begin
      tick();
      if (halted) break;
      k++;
    end
    chk("tmo_halt_cycle", 32'(k), 32'd65);
    chk("tmo_fault", 32'(fault), 32'd1);
    chk("tmo_ready", 32'(instr_ready), 32'd0);
    instr_valid = 1'b1;
    opcode      = 5'd0;
    for (int i = 0; i < 5; i++) tick();
    instr_valid = 1'b0;
    @(negedge clk);
    chk("tmo_still_halted", 32'(halted), 32'd1);
    chk("tmo_still_not_ready", 32'(instr_ready), 32'd0);
    do_reset();

    // 5: unimplemented opcode 9
`ifdef CTRL_ILLEGAL_TRAP_EN
    push(K_HALT, 5'd0, 1'b1);
`endif
    issue(5'd9);
    @(negedge clk);
    chk("ill_decode_func", 32'(alu_func), 32'd9);
    @(negedge clk);
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("ill_halted", 32'(halted), 32'd1);
    chk("ill_fault", 32'(fault), 32'd1);
    do_reset();
`else
    chk("ill_back_ready", 32'(instr_ready), 32'd1);
    chk("ill_no_we3", 32'(we3), 32'd0);
    chk("ill_no_fault", 32'(fault), 32'd0);
    push(K_WB, 5'd1, 1'b0);
    issue(5'd1);
    @(negedge clk);
    @(negedge clk);
    chk("ill_next_we3", 32'(we3), 32'd1);
`endif

    // 6: back-to-back 1, 5, HLT with valid held high
    tick();
    push(K_WB, 5'd1, 1'b0);
    push(K_WB, 5'd5, 1'b0);
    push(K_HALT, 5'd0, 1'b0);
    instr_valid = 1'b1;
    opcode      = 5'd1;
    wb1 = -1;
    wb2 = -1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) opcode = 5'd5;
      if (c == 3) opcode = 5'd31;
      @(negedge clk);
      if (we3) begin
        if (wb1 < 0) wb1 = c;
        else if (wb2 < 0) wb2 = c;
      end
    end
    instr_valid = 1'b0;
    chk("b2b_first_wb", 32'(wb1), 32'd1);
    chk("b2b_wb_spacing", 32'(wb2 - wb1), 32'd3);
    chk("b2b_halted", 32'(halted), 32'd1);
    chk("b2b_ready", 32'(instr_ready), 32'd0);

    tick();
    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
